// File: rtl/scope_frame_packer.sv
// scope_frame_packer: arms on request and waits for a rising-edge trigger on
// the ADC stream. It then captures DEPTH samples and streams a framed packet
// (A5 5A len_hi len_lo samples... checksum) over a valid/ready byte handshake.
// Optional build macro: AUTO_TRIGGER_EN forces a trigger after AUTO_TIMEOUT
// valid samples in ARMED without a real edge.
module scope_frame_packer #(
    parameter int DEPTH        = 256,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic [7:0] trig_level,
    input  logic       arm,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int            AW          = $clog2(DEPTH);
    localparam int            CW          = $clog2(DEPTH + 5) + 1;
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CSUM_IDX    = CW'(DEPTH + 4);
    localparam logic [CW-1:0] ALL_LOADED  = CW'(DEPTH + 5);
    localparam logic [15:0]   DEPTH_W     = 16'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_SEND} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_mem [DEPTH];
    logic [7:0]    r_rd_data;
    logic [7:0]    r_prev_sample;
    logic          r_prev_valid;
    logic [CW-1:0] r_wr_idx;
    logic [7:0]    r_csum;
    logic [CW-1:0] r_byte_idx;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_frame_done;

    logic          w_trigger;
    logic          w_cap_last;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic          w_load;
    logic          w_xfer;
    logic          w_last_xfer;
    logic [CW-1:0] w_next_idx;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_byte;

`ifdef AUTO_TRIGGER_EN
    localparam int             ACW      = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [ACW-1:0] AUTO_MAX = ACW'(AUTO_TIMEOUT);
    logic [ACW-1:0] r_auto_cnt;

    // Count non-triggering valid samples in ARMED; cleared outside ARMED and on trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_auto_cnt <= '0;
        end else if (r_state != S_ARMED || w_trigger) begin
            r_auto_cnt <= '0;
        end else if (sample_valid) begin
            r_auto_cnt <= r_auto_cnt + ACW'(1);
        end
    end
`endif

    // Trigger detection: a real rising crossing, or (optionally) the timeout.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_trigger = 1'b0;
        if (r_state == S_ARMED && sample_valid) begin
            if (r_prev_valid && (r_prev_sample < trig_level) && (sample >= trig_level)) begin
                w_trigger = 1'b1;
            end
`ifdef AUTO_TRIGGER_EN
            if (r_auto_cnt == AUTO_MAX) begin
                w_trigger = 1'b1;
            end
`endif
        end
    end

    assign w_cap_last  = (r_state == S_CAPTURE) && sample_valid && (r_wr_idx == LAST_SAMPLE);
    assign w_mem_we    = w_trigger || ((r_state == S_CAPTURE) && sample_valid);
    assign w_mem_addr  = w_trigger ? '0 : r_wr_idx[AW-1:0];
    assign w_xfer      = r_tx_valid && tx_ready;
    assign w_load      = (r_state == S_SEND) && (!r_tx_valid || tx_ready) && (r_byte_idx <= CSUM_IDX);
    assign w_last_xfer = (r_state == S_SEND) && w_xfer && (r_byte_idx == ALL_LOADED);
    // Address the sample needed by the byte index that will be current next cycle.
    assign w_next_idx  = w_load ? r_byte_idx + CW'(1) : r_byte_idx;
    assign w_rd_addr   = AW'(w_next_idx - CW'(4));

    // State register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the busy flag.
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    if (arm)         w_state_next = S_ARMED;
            S_ARMED:   if (w_trigger)   w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_cap_last)  w_state_next = S_SEND;
            S_SEND:    if (w_last_xfer) w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // Trigger history, capture write pointer and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_sample <= 8'h00;
            r_prev_valid  <= 1'b0;
            r_wr_idx      <= '0;
            r_csum        <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: r_prev_valid <= 1'b0;
                S_ARMED: begin
                    if (sample_valid) begin
                        r_prev_sample <= sample;
                        r_prev_valid  <= 1'b1;
                        if (w_trigger) begin
                            r_wr_idx <= CW'(1);
                            r_csum   <= sample;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        r_wr_idx <= r_wr_idx + CW'(1);
                        r_csum   <= r_csum + sample;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sample buffer: synchronous write during capture, synchronous prefetch read.
    // NOTE: the buffer and its read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= sample;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Select the byte for the current frame position.
    always_comb begin
        w_byte = r_rd_data;
        if (r_byte_idx == CW'(0))      w_byte = 8'hA5;
        else if (r_byte_idx == CW'(1)) w_byte = 8'h5A;
        else if (r_byte_idx == CW'(2)) w_byte = DEPTH_W[15:8];
        else if (r_byte_idx == CW'(3)) w_byte = DEPTH_W[7:0];
        else if (r_byte_idx == CSUM_IDX) w_byte = r_csum;
    end

    // Output byte register: reload whenever empty or being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_idx   <= '0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_xfer;
            if (r_state != S_SEND) begin
                r_byte_idx <= '0;
                r_tx_valid <= 1'b0;
            end else if (w_load) begin
                r_tx_data  <= w_byte;
                r_tx_valid <= 1'b1;
                r_byte_idx <= r_byte_idx + CW'(1);
            end else if (w_xfer) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign frame_done = r_frame_done;

endmodule
